// File: rtl/dll_tx_arbiter.sv
// dll_tx_arbiter: multiplexes Ack/Nak DLLPs, UpdateFC DLLPs and retry-buffer TLP beats onto PIPE TX,
// and keeps the per-class UpdateFC refresh timers.
module dll_tx_arbiter #(
   parameter int PIPE_DATA_WIDTH = 256,
   parameter int UFC_PERIOD      = 1024,
   parameter int UFC_CNT_W       = 11
) (
   input  logic                       sclk,
   input  logic                       srst_n,
   input  logic                       link_active_i,
   input  logic                       tlp_valid_i,
   input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
   input  logic                       tlp_last_i,
   output logic                       tlp_ready_o,
   input  logic                       ack_req_i,
   input  logic [47:0]                ack_dllp_i,
   output logic                       ack_gnt_o,
   input  logic [2:0]                 fc_req_i,
   input  logic [143:0]               fc_dllp_i,
   output logic [2:0]                 fc_gnt_o,
   output logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o,
   output logic                       pipe_txvalid_o,
   output logic                       pipe_txdllp_o
);
   localparam logic [UFC_CNT_W-1:0] TMAX = UFC_CNT_W'(UFC_PERIOD - 1);

   typedef enum logic {IDLE, IN_TLP} state_t;

   state_t               state;
   logic [2:0]           pend, urg, at_max, urg_eff, fc_sel;
   logic [UFC_CNT_W-1:0] tmr [3];
   logic                 idle_ok, dllp_gnt;
   logic [47:0]          dllp;

   for (genvar i = 0; i < 3; i++) begin : g_max
      assign at_max[i] = tmr[i] == TMAX;
   end

   // A class turns urgent the very cycle its timer saturates, not one cycle later.
   always_comb begin
      urg_eff     = urg | at_max;
      idle_ok     = link_active_i && state == IDLE;
      ack_gnt_o   = idle_ok && ack_req_i;
      fc_sel      = |urg_eff ? urg_eff : (tlp_valid_i ? 3'b000 : pend);
      fc_gnt_o    = (idle_ok && !ack_req_i) ? (fc_sel & (~fc_sel + 3'd1)) : 3'b000;
      tlp_ready_o = link_active_i && tlp_valid_i
                    && (state == IN_TLP || (!ack_req_i && !(|urg_eff)));
      dllp_gnt    = ack_gnt_o || |fc_gnt_o;
      dllp        = ack_gnt_o   ? ack_dllp_i
                  : fc_gnt_o[0] ? fc_dllp_i[47:0]
                  : fc_gnt_o[1] ? fc_dllp_i[95:48]
                  :               fc_dllp_i[143:96];
   end

   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         state          <= IDLE;
         pend           <= '0;
         urg            <= '0;
         for (int i = 0; i < 3; i++) tmr[i] <= '0;
         pipe_txdata_o  <= '0;
         pipe_txvalid_o <= 1'b0;
         pipe_txdllp_o  <= 1'b0;
      end else begin
         pipe_txvalid_o <= tlp_ready_o || dllp_gnt;
         pipe_txdllp_o  <= dllp_gnt;
         pipe_txdata_o  <= tlp_ready_o ? tlp_data_i
                         : dllp_gnt    ? PIPE_DATA_WIDTH'(dllp)
                         :               '0;
         if (!link_active_i) begin
            state <= IDLE;
            pend  <= '0;
            urg   <= '0;
            for (int i = 0; i < 3; i++) tmr[i] <= '0;
         end else begin
            if (tlp_ready_o) state <= tlp_last_i ? IDLE : IN_TLP;
            pend <= (pend | fc_req_i) & ~fc_gnt_o;
            urg  <= (urg | at_max) & ~fc_gnt_o;
            for (int i = 0; i < 3; i++)
               tmr[i] <= fc_gnt_o[i] ? '0 : (at_max[i] ? tmr[i] : tmr[i] + UFC_CNT_W'(1));
         end
      end
   end
endmodule
